// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared byte width, ASCII constants and drain-FSM encodings for uart_tx_fifo.
package uart_tx_fifo_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2
  } drain_state_t;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with a separate occupancy counter.
module sync_fifo #(
  parameter int DEPTH_LOG = 4,
  parameter int W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_x,
  input  logic               i_push,
  input  logic [W-1:0]       i_data,
  input  logic               i_pop,
  output logic [W-1:0]       o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH_LOG:0] o_count
);
  logic [W-1:0]         r_mem [2**DEPTH_LOG];
  logic [DEPTH_LOG-1:0] r_wr;
  logic [DEPTH_LOG-1:0] r_rd;
  logic [DEPTH_LOG:0]   r_count;
  logic                 w_push;
  logic                 w_pop;
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = r_count[DEPTH_LOG];
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= w_push ? (w_pop ? r_count : r_count + 1'b1) : (w_pop ? r_count - 1'b1 : r_count);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO draining to a UART transmitter with a sticky overflow flag.
// Defining UART_TX_FIFO_CRLF_EN inserts a CR before every LF on the transmit side.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG = 4
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [BYTE_W-1:0]  IN_DATA,
  input  logic               IN_WE,
  output logic               IN_READY,
  output logic [BYTE_W-1:0]  OUT_DATA,
  output logic               OUT_WE,
  input  logic               OUT_READY,
  output logic [DEPTH_LOG:0] COUNT,
  output logic               EMPTY,
  output logic               OVERFLOW
);
  drain_state_t      r_state;
  logic [BYTE_W-1:0] r_out_data;
  logic              r_out_we;
  logic              r_overflow;
  logic [BYTE_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_ins_cr;
  logic              w_start;
  sync_fifo #(.DEPTH_LOG(DEPTH_LOG), .W(BYTE_W)) u_fifo (
    .i_clk   (CLK),
    .i_rst_x (RST_X),
    .i_push  (IN_WE),
    .i_data  (IN_DATA),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (COUNT)
  );
  assign w_start = r_state == IDLE && !w_empty && OUT_READY;
`ifdef UART_TX_FIFO_CRLF_EN
  logic r_cr_sent;
  // cr_sent is set when a CR is issued for the head LF; the LF issue clears it and pops.
  assign w_ins_cr = w_head == ASCII_LF && !r_cr_sent;
  assign w_pop    = r_state == ISSUE && !r_cr_sent;
  always_ff @(posedge CLK) begin
    r_cr_sent <= !RST_X ? 1'b0 : w_start ? w_ins_cr : r_cr_sent;
  end
`else
  assign w_ins_cr = 1'b0;
  assign w_pop    = r_state == ISSUE;
`endif
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state    <= IDLE;
      r_out_data <= '0;
      r_out_we   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (IN_WE && w_full) r_overflow <= 1'b1;
      case (r_state)
        IDLE: if (w_start) begin
          r_state    <= ISSUE;
          r_out_we   <= 1'b1;
          r_out_data <= w_ins_cr ? ASCII_CR : w_head;
        end
        ISSUE: begin
          r_state  <= GUARD;
          r_out_we <= 1'b0;
        end
        GUARD:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign IN_READY = !w_full;
  assign EMPTY    = w_empty;
  assign OVERFLOW = r_overflow;
  assign OUT_DATA = r_out_data;
  assign OUT_WE   = r_out_we;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with a transmitter model that holds READY low 10 cycles per byte.
module tb_uart_tx_fifo;
  logic       CLK = 1'b0;
  logic       RST_X = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_WE = 1'b0;
  logic       IN_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_WE;
  logic       OUT_READY;
  logic [4:0] COUNT;
  logic       EMPTY;
  logic       OVERFLOW;
  logic       tx_en = 1'b0;
  logic       prev_we = 1'b0;
  int         busy = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  always #5 CLK = ~CLK;
  assign OUT_READY = tx_en && busy == 0;
  uart_tx_fifo #(.DEPTH_LOG(4)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .IN_DATA   (IN_DATA),
    .IN_WE     (IN_WE),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_WE    (OUT_WE),
    .OUT_READY (OUT_READY),
    .COUNT     (COUNT),
    .EMPTY     (EMPTY),
    .OVERFLOW  (OVERFLOW)
  );
  initial forever begin
    @(negedge CLK);
    if (OUT_WE) busy = 10;
    else if (busy > 0) busy--;
  end
  initial forever begin
    @(negedge CLK);
    if (OUT_WE) begin
      tests++;
      if (prev_we) begin
        fails++;
        $display("FAIL out_we_width: OUT_WE high two cycles in a row, required one");
      end
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got %h, required no output", OUT_DATA);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (OUT_DATA !== e) begin
          fails++;
          $display("FAIL out_data: got %h, required %h", OUT_DATA, e);
        end
      end
    end
    prev_we = OUT_WE;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] b, input bit queued);
    IN_DATA = b;
    IN_WE = 1'b1;
    if (queued) exp_q.push_back(b);
    @(negedge CLK);
    IN_WE = 1'b0;
  endtask
  task automatic do_reset(input string n);
    @(negedge CLK);
    RST_X = 1'b0;
    IN_WE = 1'b0;
    @(negedge CLK);
    RST_X = 1'b1;
    exp_q.delete();
    chk({n, "_count"}, COUNT, 0);
    chk({n, "_empty"}, EMPTY, 1);
    chk({n, "_in_ready"}, IN_READY, 1);
    chk({n, "_out_we"}, OUT_WE, 0);
    chk({n, "_out_data"}, OUT_DATA, 0);
    chk({n, "_overflow"}, OVERFLOW, 0);
  endtask
  task automatic wait_drain(input string n);
    for (int k = 0; k < 600 && (exp_q.size() != 0 || !EMPTY); k++) @(negedge CLK);
    chk({n, "_drained"}, exp_q.size(), 0);
    chk({n, "_empty"}, EMPTY, 1);
    repeat (14) @(negedge CLK);
  endtask
  initial begin
    do_reset("rst0");
    tx_en = 1'b1;
    push(8'h41, 1'b1);
    chk("sb_count1", COUNT, 1);
    chk("sb_we_early", OUT_WE, 0);
    @(negedge CLK);
    chk("sb_we", OUT_WE, 1);
    chk("sb_data", OUT_DATA, 8'h41);
    @(negedge CLK);
    chk("sb_we_low", OUT_WE, 0);
    chk("sb_count0", COUNT, 0);
    wait_drain("sb");
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("fill_ready", IN_READY, 0);
    chk("fill_count", COUNT, 16);
    push(8'hFF, 1'b0);
    chk("fill_ovf", OVERFLOW, 1);
    chk("fill_ovf_count", COUNT, 16);
    tx_en = 1'b1;
    wait_drain("fill");
    do_reset("rst1");
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 200 && !IN_READY; k++) @(negedge CLK);
      push(8'(i * 37 + 5), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_drain("wrap");
    chk("wrap_ovf", OVERFLOW, 0);
    do_reset("rst2");
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b1);
    chk("fp_ovf0", OVERFLOW, 0);
    tx_en = 1'b1;
    @(negedge CLK);
    chk("fp_issue", OUT_WE, 1);
    push(8'hEE, 1'b0);
    chk("fp_ovf", OVERFLOW, 1);
    chk("fp_count", COUNT, 15);
    chk("fp_ready", IN_READY, 1);
    wait_drain("fp");
    do_reset("rst3");
    push(8'h48, 1'b1);
`ifdef UART_TX_FIFO_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    push(8'h0A, 1'b1);
    wait_drain("crlf");
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b1);
    chk("mr_count5", COUNT, 5);
    tx_en = 1'b1;
    for (int k = 0; k < 50 && !OUT_WE; k++) @(negedge CLK);
    chk("mr_issue", OUT_WE, 1);
    RST_X = 1'b0;
    @(negedge CLK);
    RST_X = 1'b1;
    chk("mr_count", COUNT, 0);
    chk("mr_out_we", OUT_WE, 0);
    chk("mr_overflow", OVERFLOW, 0);
    chk("mr_empty", EMPTY, 1);
    exp_q.delete();
    repeat (20) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
